// File: rtl/load_mem_port_if.sv
// Bundles the load request/response, branch resolution, store-buffer lookup/retire
// and dmem signals of the load memory port.
interface load_mem_port_if #(
   parameter int ADDR_LEN    = 16,
   parameter int DATA_LEN    = 32,
   parameter int SPECTAG_LEN = 4
) ();
   logic                   ld_req_valid;
   logic                   ld_req_ready;
   logic [ADDR_LEN-1:0]    ld_req_addr;
   logic                   ld_req_specbit;
   logic [SPECTAG_LEN-1:0] ld_req_spectag;
   logic                   ld_resp_valid;
   logic                   ld_resp_ready;
   logic [DATA_LEN-1:0]    ld_resp_data;
   logic                   ld_resp_fwd;
   logic                   prmiss;
   logic                   prsuccess;
   logic [SPECTAG_LEN-1:0] prtag;
   logic [SPECTAG_LEN-1:0] spectagfix;
   logic [ADDR_LEN-1:0]    sb_ldaddr;
   logic                   sb_hit;
   logic [DATA_LEN-1:0]    sb_lddata;
   logic                   memoccupy_ld;
   logic                   stretire;
   logic [ADDR_LEN-1:0]    retaddr;
   logic [DATA_LEN-1:0]    retdata;
   logic [ADDR_LEN-1:0]    dmem_addr;
   logic                   dmem_we;
   logic [DATA_LEN-1:0]    dmem_wdata;
   logic [DATA_LEN-1:0]    dmem_rdata;

   modport slave (
      input  ld_req_valid, ld_req_addr, ld_req_specbit, ld_req_spectag, ld_resp_ready,
             prmiss, prsuccess, prtag, spectagfix, sb_hit, sb_lddata,
             stretire, retaddr, retdata, dmem_rdata,
      output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd, sb_ldaddr,
             memoccupy_ld, dmem_addr, dmem_we, dmem_wdata
   );

   modport master (
      output ld_req_valid, ld_req_addr, ld_req_specbit, ld_req_spectag, ld_resp_ready,
             prmiss, prsuccess, prtag, spectagfix, sb_hit, sb_lddata,
             stretire, retaddr, retdata, dmem_rdata,
      input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd, sb_ldaddr,
             memoccupy_ld, dmem_addr, dmem_we, dmem_wdata
   );
endinterface

// File: rtl/load_mem_port.sv
// Load port onto the shared dmem: forwards store-buffer hits, otherwise reads dmem
// with fixed latency while blocking store retirement; speculative loads can be killed.
module load_mem_port #(
   parameter int ADDR_LEN    = 16,
   parameter int DATA_LEN    = 32,
   parameter int SPECTAG_LEN = 4,
   parameter int RD_LAT      = 1
) (
   input  logic             clk,
   input  logic             reset,
   load_mem_port_if.slave   bus
);
   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, RD, WAIT, RESP} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_specbit;
   logic [ADDR_LEN-1:0]    r_addr;
   logic [SPECTAG_LEN-1:0] r_spectag;
   logic [DATA_LEN-1:0]    r_data;
   logic                   r_fwd;

   logic w_accept;
   logic w_kill;
   logic w_occupy;
   logic w_resolve;

   assign w_accept  = (r_state == IDLE) && bus.ld_req_valid && !bus.prmiss;
   assign w_kill    = (r_state != IDLE) && bus.prmiss && r_specbit &&
                      ((bus.spectagfix & r_spectag) != '0);
   assign w_occupy  = (r_state == RD) || (r_state == WAIT);
   assign w_resolve = bus.prsuccess && r_specbit && (bus.prtag == r_spectag);

   always_comb begin
      w_state_nxt       = r_state;
      bus.ld_req_ready  = (r_state == IDLE) && !bus.prmiss;
      bus.sb_ldaddr     = bus.ld_req_addr;
      bus.ld_resp_valid = (r_state == RESP) && !w_kill;
      bus.ld_resp_data  = (r_state == RESP) ? r_data : '0;
      bus.ld_resp_fwd   = (r_state == RESP) && r_fwd;
      bus.memoccupy_ld  = w_occupy;
      bus.dmem_addr     = w_occupy ? r_addr : bus.retaddr;
      bus.dmem_we       = !w_occupy && bus.stretire;
      bus.dmem_wdata    = bus.retdata;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = bus.sb_hit ? RESP : RD;
         RD:      w_state_nxt = WAIT;
         WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
         RESP:    if (bus.ld_resp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // A mispredict kill wins over every transition, including the response handshake.
      if (w_kill) w_state_nxt = IDLE;
   end

   // Control state: the only registers that see reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_specbit <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == RD)
            r_cnt <= CNT_W'(RD_LAT - 1);
         else if ((r_state == WAIT) && (r_cnt != '0))
            r_cnt <= r_cnt - CNT_W'(1);
         if (w_accept)
            r_specbit <= bus.ld_req_specbit;
         else if (w_resolve)
            r_specbit <= 1'b0;
      end
   end

   // Load payload: captured at accept, data refilled when the dmem read lands.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr    <= bus.ld_req_addr;
         r_spectag <= bus.ld_req_spectag;
         r_fwd     <= bus.sb_hit;
         if (bus.sb_hit) r_data <= bus.sb_lddata;
      end else if ((r_state == WAIT) && (r_cnt == '0)) begin
         r_data <= bus.dmem_rdata;
      end
   end
endmodule

// File: tb/tb_load_mem_port.sv
// Directed and randomized checks of load_mem_port against a memory/latency model.
module tb_load_mem_port;
   localparam int ADDR_LEN    = 16;
   localparam int DATA_LEN    = 32;
   localparam int SPECTAG_LEN = 4;
   localparam int RD_LAT      = 1;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [DATA_LEN-1:0] dmem    [0:65535];
   logic [DATA_LEN-1:0] ref_mem [0:65535];
   logic [DATA_LEN-1:0] rd_pipe [0:RD_LAT-1];
   logic [ADDR_LEN-1:0] set_addr [0:15];

   always #5 clk = ~clk;

   load_mem_port_if #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .SPECTAG_LEN(SPECTAG_LEN)) bus ();

   load_mem_port #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN), .SPECTAG_LEN(SPECTAG_LEN),
                   .RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous dmem with RD_LAT cycles of read latency.
   always @(posedge clk) begin
      if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
      rd_pipe[0] <= dmem[bus.dmem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.dmem_rdata = rd_pipe[RD_LAT-1];

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_req();
      bus.ld_req_valid = 1'b0;
      bus.sb_hit       = 1'b0;
      bus.stretire     = 1'b0;
      bus.prmiss       = 1'b0;
      bus.prsuccess    = 1'b0;
      bus.prtag        = '0;
      bus.spectagfix   = '0;
   endtask

   task automatic store(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.stretire = 1'b1;
      bus.retaddr  = a;
      bus.retdata  = d;
      #1;
      chk("st_we", bus.dmem_we, 1);
      chk("st_addr", bus.dmem_addr, a);
      chk("st_wdata", bus.dmem_wdata, d);
      @(posedge clk);
      ref_mem[a] = d;
      @(negedge clk);
      bus.stretire = 1'b0;
   endtask

   task automatic accept(input logic [15:0] a, input logic spec, input logic [3:0] tag,
                         input logic hit, input logic [31:0] hd);
      @(negedge clk);
      bus.ld_req_valid   = 1'b1;
      bus.ld_req_addr    = a;
      bus.ld_req_specbit = spec;
      bus.ld_req_spectag = tag;
      bus.sb_hit         = hit;
      bus.sb_lddata      = hd;
      #1;
      chk("req_ready", bus.ld_req_ready, 1);
      chk("sb_ldaddr", bus.sb_ldaddr, a);
      @(posedge clk);
   endtask

   // Expects a response exp_lat cycles after the last edge, with exp_occ port-held cycles.
   task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                            input logic exp_fwd, input int exp_occ, input logic [15:0] a,
                            input int bp, input bit inject);
      int lat = 0;
      int occ = 0;
      bit got = 1'b0;
      for (int c = 1; c <= 30 && !got; c++) begin
         @(negedge clk);
         clear_req();
         if (bus.memoccupy_ld && inject) begin
            bus.stretire = 1'b1;
            bus.retaddr  = 16'($urandom);
            bus.retdata  = $urandom;
         end
         #1;
         if (bus.memoccupy_ld) begin
            occ++;
            chk({tag, "_no_we"}, bus.dmem_we, 0);
            chk({tag, "_rdaddr"}, bus.dmem_addr, a);
         end
         if (bus.ld_resp_valid) begin
            got = 1'b1;
            lat = c;
         end
      end
      bus.stretire = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_occ"}, occ, exp_occ);
      chk({tag, "_data"}, bus.ld_resp_data, exp_data);
      chk({tag, "_fwd"}, bus.ld_resp_fwd, exp_fwd);
      for (int i = 0; i < bp; i++) begin
         chk({tag, "_bp_valid"}, bus.ld_resp_valid, 1);
         chk({tag, "_bp_data"}, bus.ld_resp_data, exp_data);
         chk({tag, "_bp_rdy"}, bus.ld_req_ready, 0);
         @(negedge clk);
         bus.ld_req_valid = 1'b1;
         #1;
      end
      bus.ld_req_valid  = 1'b0;
      bus.ld_resp_ready = 1'b1;
      #1;
      chk({tag, "_hs_valid"}, bus.ld_resp_valid, 1);
      @(posedge clk);
      @(negedge clk);
      bus.ld_resp_ready = 1'b0;
      #1;
      chk({tag, "_done_valid"}, bus.ld_resp_valid, 0);
      chk({tag, "_done_rdy"}, bus.ld_req_ready, 1);
   endtask

   task automatic watch_no_resp(input string tag);
      int seen = 0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (bus.ld_resp_valid) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      reset = 1'b0;
      clear_req();
      bus.ld_req_addr    = '0;
      bus.ld_req_specbit = 1'b0;
      bus.ld_req_spectag = '0;
      bus.ld_resp_ready  = 1'b0;
      bus.sb_lddata      = '0;
      bus.retaddr        = '0;
      bus.retdata        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid", bus.ld_resp_valid, 0);
      chk("rst_fwd", bus.ld_resp_fwd, 0);
      chk("rst_data", bus.ld_resp_data, 0);
      chk("rst_occ", bus.memoccupy_ld, 0);
      reset = 1'b1;

      store(16'h0010, 32'h12345678);
      store(16'h0030, 32'hCAFEF00D);

      accept(16'h0040, 1'b0, 4'h0, 1'b1, 32'hDEADBEEF);
      wait_resp("hit", 1, 32'hDEADBEEF, 1'b1, 0, 16'h0040, 0, 1'b0);

      accept(16'h0010, 1'b0, 4'h0, 1'b0, 32'h0);
      wait_resp("miss", RD_LAT + 2, ref_mem[16'h0010], 1'b0, RD_LAT + 1, 16'h0010, 0, 1'b0);

      store(16'h0020, 32'hA5A5A5A5);
      accept(16'h0020, 1'b0, 4'h0, 1'b0, 32'h0);
      wait_resp("miss_st", RD_LAT + 2, 32'hA5A5A5A5, 1'b0, RD_LAT + 1, 16'h0020, 0, 1'b1);

      // Speculative miss killed while the read is outstanding.
      accept(16'h0030, 1'b1, 4'b0010, 1'b0, 32'h0);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      bus.prmiss     = 1'b1;
      bus.spectagfix = 4'b0110;
      #1;
      chk("kill_wait_occ", bus.memoccupy_ld, 1);
      @(negedge clk);
      clear_req();
      #1;
      chk("kill_occ", bus.memoccupy_ld, 0);
      chk("kill_valid", bus.ld_resp_valid, 0);
      chk("kill_rdy", bus.ld_req_ready, 1);
      watch_no_resp("kill_no_resp");

      // Same load, resolved first: the later mispredict leaves it alone.
      accept(16'h0030, 1'b1, 4'b0010, 1'b0, 32'h0);
      @(negedge clk);
      clear_req();
      bus.prsuccess = 1'b1;
      bus.prtag     = 4'b0010;
      @(negedge clk);
      clear_req();
      bus.prmiss     = 1'b1;
      bus.spectagfix = 4'b0110;
      #1;
      chk("surv_occ", bus.memoccupy_ld, 1);
      wait_resp("survive", RD_LAT, 32'hCAFEF00D, 1'b0, RD_LAT - 1, 16'h0030, 0, 1'b0);

      // Non-speculative load ignores a mispredict.
      accept(16'h0010, 1'b0, 4'b0001, 1'b0, 32'h0);
      @(negedge clk);
      clear_req();
      bus.prmiss     = 1'b1;
      bus.spectagfix = 4'hF;
      wait_resp("nonspec", RD_LAT + 1, 32'h12345678, 1'b0, RD_LAT, 16'h0010, 0, 1'b0);

      // Kill beats the response handshake.
      accept(16'h0050, 1'b1, 4'b0001, 1'b1, 32'h11112222);
      @(negedge clk);
      clear_req();
      bus.ld_resp_ready = 1'b1;
      bus.prmiss        = 1'b1;
      bus.spectagfix    = 4'b0001;
      #1;
      chk("kresp_valid", bus.ld_resp_valid, 0);
      @(negedge clk);
      clear_req();
      bus.ld_resp_ready = 1'b0;
      #1;
      chk("kresp_after", bus.ld_resp_valid, 0);
      chk("kresp_rdy", bus.ld_req_ready, 1);

      // Request during mispredict is refused.
      @(negedge clk);
      bus.ld_req_valid = 1'b1;
      bus.ld_req_addr  = 16'h0070;
      bus.prmiss       = 1'b1;
      #1;
      chk("prmiss_rdy", bus.ld_req_ready, 0);
      @(negedge clk);
      clear_req();
      #1;
      chk("prmiss_noacc", bus.memoccupy_ld, 0);
      watch_no_resp("prmiss_no_resp");

      accept(16'h0060, 1'b0, 4'h0, 1'b1, 32'h0BADCAFE);
      wait_resp("bp", 1, 32'h0BADCAFE, 1'b1, 0, 16'h0060, 5, 1'b0);

      // Reset while waiting on dmem.
      accept(16'h0010, 1'b0, 4'h0, 1'b0, 32'h0);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst_occ", bus.memoccupy_ld, 0);
      chk("mrst_valid", bus.ld_resp_valid, 0);
      chk("mrst_rdy", bus.ld_req_ready, 1);
      watch_no_resp("mrst_no_resp");

      for (int i = 0; i < 16; i++) begin
         set_addr[i] = 16'h0100 + 16'(i * 4);
         store(set_addr[i], $urandom);
      end
      for (int it = 0; it < 40; it++) begin
         int op;
         logic [15:0] a;
         logic [31:0] d;
         op = $urandom_range(0, 2);
         a  = set_addr[$urandom_range(0, 15)];
         d  = $urandom;
         if (op == 0) begin
            store(a, d);
         end else if (op == 1) begin
            a = 16'($urandom);
            accept(a, 1'b0, 4'h0, 1'b1, d);
            wait_resp("rnd_hit", 1, d, 1'b1, 0, a, $urandom_range(0, 2), 1'b0);
         end else begin
            accept(a, 1'b0, 4'h0, 1'b0, 32'h0);
            wait_resp("rnd_miss", RD_LAT + 2, ref_mem[a], 1'b0, RD_LAT + 1, a,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
